// File: rtl/local_eject_buffer.sv
// Router local-port eject FIFO feeding the PE collector over Req/Gnt, one packet per handshake.
// Write-to-Req 2 cycles on an empty FIFO; Full stalls the crossbar and DnStrFull holds off new requests.
module local_eject_buffer #(
  parameter int dataWidth = 32,
  parameter int DEPTH     = 4,
  parameter int PTR_W     = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [dataWidth-1:0] PacketIn,
  input  logic                 WrReq,
  output logic                 Full,
  output logic [dataWidth-1:0] PacketOut,
  output logic                 ReqDnStr,
  input  logic                 GntDnStr,
  input  logic                 DnStrFull,
  output logic [PTR_W:0]       Count,
  output logic                 Overflow
);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  state_t               state, nextState;
  logic [dataWidth-1:0] mem [DEPTH];
  logic [PTR_W-1:0]     wrPtr, rdPtr;
  logic                 wrAccept, pop, load;

  // Full comes from the registered count only, so a same-cycle pop never frees room for a write.
  assign Full     = (Count == CNT_FULL);
  assign wrAccept = WrReq & ~Full;
  assign ReqDnStr = (state == SEND);

  always_comb begin
    nextState = state;
    pop       = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (Count != '0 && !DnStrFull) begin
          load      = 1'b1;
          nextState = SEND;
        end
      end
      SEND: begin
        if (GntDnStr) begin
          pop       = 1'b1;
          nextState = GAP;
        end
      end
      GAP:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      Count     <= '0;
      Overflow  <= 1'b0;
      PacketOut <= '0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + PTR_ONE;
      if (pop)      rdPtr <= rdPtr + PTR_ONE;
      if (WrReq && Full) Overflow <= 1'b1;
      if (load)     PacketOut <= mem[rdPtr];
      case ({wrAccept, pop})
        2'b10:   Count <= Count + CNT_ONE;
        2'b01:   Count <= Count - CNT_ONE;
        default: Count <= Count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wrAccept) mem[wrPtr] <= PacketIn;
  end

endmodule

// File: tb/tb_local_eject_buffer.sv
// Randomized and directed bench for local_eject_buffer against a queue-based packet model.
module tb_local_eject_buffer;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PacketIn;
  logic        WrReq;
  logic        Full;
  logic [31:0] PacketOut;
  logic        ReqDnStr;
  logic        GntDnStr;
  logic        DnStrFull;
  logic [2:0]  Count;
  logic        Overflow;

  local_eject_buffer #(.dataWidth(32), .DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .reset(reset), .PacketIn(PacketIn), .WrReq(WrReq), .Full(Full),
    .PacketOut(PacketOut), .ReqDnStr(ReqDnStr), .GntDnStr(GntDnStr),
    .DnStrFull(DnStrFull), .Count(Count), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] q[$];
  logic [31:0] log_q[$];
  logic [31:0] sent[$];
  logic        ovf;
  logic        gntEn;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, model the edge, then compare at the next negedge.
  task automatic tick(input logic wr, input logic [31:0] d);
    logic reqPre, gntPre, dnPre, popNow;
    int   szPre;
    WrReq    = wr;
    PacketIn = d;
    reqPre   = ReqDnStr;
    gntPre   = GntDnStr;
    dnPre    = DnStrFull;
    szPre    = q.size();
    if (reqPre) begin
      if (q.size() == 0) chk("req_while_empty", 64'(reqPre), 64'(0));
      else               chk("pkt_data", 64'(PacketOut), 64'(q[0]));
    end
    @(posedge clk);
    popNow = reqPre && gntPre;
    if (wr) begin
      if (szPre == DEPTH) ovf = 1'b1;
      else                q.push_back(d);
    end
    if (popNow && q.size() > 0) log_q.push_back(q.pop_front());
    @(negedge clk);
    WrReq    = 1'b0;
    GntDnStr = reqPre && !gntPre && gntEn;
    chk("count", 64'(Count), 64'(q.size()));
    chk("full", 64'(Full), 64'(q.size() == DEPTH));
    chk("overflow", 64'(Overflow), 64'(ovf));
    if (popNow) chk("gap_req", 64'(ReqDnStr), 64'(0));
    if (!reqPre && dnPre) chk("stall_req", 64'(ReqDnStr), 64'(0));
  endtask

  task automatic doReset();
    reset    = 1'b0;
    WrReq    = 1'b1;
    PacketIn = 32'hFFFF_0000;
    GntDnStr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_full", 64'(Full), 64'(0));
    chk("rst_req", 64'(ReqDnStr), 64'(0));
    chk("rst_count", 64'(Count), 64'(0));
    chk("rst_ovf", 64'(Overflow), 64'(0));
    chk("rst_pkt", 64'(PacketOut), 64'(0));
    reset = 1'b1;
    WrReq = 1'b0;
    q.delete();
    ovf = 1'b0;
  endtask

  task automatic drain(input string tag);
    logic done;
    done = 1'b0;
    DnStrFull = 1'b0;
    gntEn = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      tick(1'b0, 32'h0);
      done = (q.size() == 0) && !ReqDnStr;
    end
    chk(tag, 64'(done), 64'(1));
  endtask

  initial begin
    logic        found;
    logic [31:0] d;
    int          accepted;
    reset = 1'b0; WrReq = 1'b0; PacketIn = '0; GntDnStr = 1'b0; DnStrFull = 1'b0;
    ovf = 1'b0; gntEn = 1'b1;

    // Reset with WrReq held high must store nothing.
    doReset();
    tick(1'b0, 32'h0);

    // Single packet and write-to-Req latency.
    log_q.delete();
    tick(1'b1, 32'h0000_A5C3);
    chk("lat_req_1", 64'(ReqDnStr), 64'(0));
    tick(1'b0, 32'h0);
    chk("lat_req_2", 64'(ReqDnStr), 64'(1));
    chk("single_pkt", 64'(PacketOut), 64'h0000_A5C3);
    drain("single_drain");
    chk("single_n", 64'(log_q.size()), 64'(1));
    if (log_q.size() == 1) chk("single_val", 64'(log_q[0]), 64'h0000_A5C3);

    // Fill with collector stalled, overflow on the fifth write.
    log_q.delete();
    DnStrFull = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1, 32'(i));
      if (i == 4) chk("fill_full", 64'(Full), 64'(1));
    end
    chk("fill_ovf", 64'(Overflow), 64'(1));
    chk("fill_count", 64'(Count), 64'(4));
    drain("fill_drain");
    chk("fill_n", 64'(log_q.size()), 64'(4));
    for (int i = 0; i < log_q.size() && i < 4; i++) chk("fill_order", 64'(log_q[i]), 64'(i + 1));

    // Ten random packets interleaved with random stalls, exercising pointer wrap.
    log_q.delete();
    sent.delete();
    accepted = 0;
    for (int i = 0; i < 400 && accepted < 10; i++) begin
      DnStrFull = ($urandom_range(3) == 0);
      if (q.size() < DEPTH && $urandom_range(1) == 1) begin
        d = $urandom;
        sent.push_back(d);
        accepted++;
        tick(1'b1, d);
      end else begin
        tick(1'b0, 32'h0);
      end
    end
    chk("wrap_sent", 64'(accepted), 64'(10));
    drain("wrap_drain");
    chk("wrap_n", 64'(log_q.size()), 64'(10));
    for (int i = 0; i < log_q.size() && i < sent.size(); i++) chk("wrap_order", 64'(log_q[i]), 64'(sent[i]));

    // Pop and write on the same edge while full: the write is dropped.
    doReset();
    DnStrFull = 1'b1;
    for (int i = 0; i < 4; i++) tick(1'b1, 32'h50 + 32'(i));
    DnStrFull = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b0, 32'h0);
      found = ReqDnStr && GntDnStr;
    end
    chk("simul_wait", 64'(found), 64'(1));
    tick(1'b1, 32'hDEAD_BEEF);
    chk("simul_count", 64'(Count), 64'(3));
    chk("simul_ovf", 64'(Overflow), 64'(1));
    drain("simul_drain");

    // Reset asserted while a request is outstanding.
    doReset();
    gntEn = 1'b0;
    tick(1'b1, 32'h77);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick(1'b0, 32'h0);
      found = ReqDnStr;
    end
    chk("midsend_wait", 64'(found), 64'(1));
    #2 reset = 1'b0;
    #1;
    chk("midsend_req", 64'(ReqDnStr), 64'(0));
    chk("midsend_count", 64'(Count), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    q.delete();
    ovf = 1'b0;
    gntEn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 32'h0);
      chk("post_rst_req", 64'(ReqDnStr), 64'(0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
